// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package seg7_pkg;

    localparam logic [7:0] SEG7_ANODES_OFF = 8'hFF;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_SHOW  = 2'd1,
        SLOT_GUARD = 2'd2
    } slot_state_t;

    // A single-digit display still needs a one-bit index.
    function automatic int seg7_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Host-facing bus of the scan multiplexer: value load strobe plus display drive outputs.
// load is a one-cycle write strobe with no ready; the scanner always accepts it and the last write before a frame boundary wins.
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = seg7_pkg::seg7_idx_w(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    seg7_pkg::nibble_t       digit_nibble;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    dp_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;
    seg7_pkg::slot_state_t   slot_state;

    modport master (
        output value, dp_in, load,
        input  digit_nibble, anode_n, dp_n, digit_idx, frame_tick, slot_state
    );

    modport slave (
        input  value, dp_in, load,
        output digit_nibble, anode_n, dp_n, digit_idx, frame_tick, slot_state
    );

endinterface

// File: rtl/seg7_slot_timer.sv
// Slot counter and digit index; all strobes describe the state being entered on the next edge.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    localparam int IDX_W = seg7_idx_w(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx_nxt,
    output logic             slot_first,
    output logic             show,
    output logic             frame_end
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W:0]   SHOW_LEN = (CNT_W + 1)'(REFRESH_DIV - BLANK_CYCLES);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx;

    // The first edge after reset enters cnt=0/digit 0 rather than advancing past it.
    always_comb begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        frame_end = 1'b0;
        if (run) begin
            if (cnt == CNT_LAST) begin
                if (idx == IDX_LAST) begin
                    frame_end = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
                idx_nxt = idx;
            end
        end
    end

    assign slot_first = (cnt_nxt == '0);
    assign show       = ({1'b0, cnt_nxt} < SHOW_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            idx <= '0;
        end else begin
            run <= 1'b1;
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Frame-coherent 7-segment scanner with shadow/pending value registers and registered outputs.
// Optional leading-zero suppression: define SEG7_SCAN_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_mux_if.slave bus
);

    localparam int IDX_W = seg7_idx_w(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] OFF = SEG7_ANODES_OFF[NUM_DIGITS-1:0];

    logic [IDX_W-1:0]        idx_nxt;
    logic                    slot_first, show, frame_end;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt, pending;
    logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt, pending_dp;
    logic                    pending_valid;
    logic [NUM_DIGITS-1:0]   suppress;

    seg7_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx_nxt   (idx_nxt),
        .slot_first(slot_first),
        .show      (show),
        .frame_end (frame_end)
    );

    // A load landing on the boundary cycle goes straight to the display.
    always_comb begin
        shadow_nxt    = shadow;
        shadow_dp_nxt = shadow_dp;
        if (frame_end) begin
            if (bus.load) begin
                shadow_nxt    = bus.value;
                shadow_dp_nxt = bus.dp_in;
            end else if (pending_valid) begin
                shadow_nxt    = pending;
                shadow_dp_nxt = pending_dp;
            end
        end
    end

`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        suppress   = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (shadow_nxt[4*k +: 4] == 4'h0);
            suppress[k] = upper_zero && !shadow_dp_nxt[k];
        end
    end
`else
    assign suppress = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            shadow        <= '0;
            shadow_dp     <= '0;
        end else begin
            if (bus.load) begin
                pending    <= bus.value;
                pending_dp <= bus.dp_in;
            end
            pending_valid <= frame_end ? 1'b0 : (pending_valid | bus.load);
            shadow        <= shadow_nxt;
            shadow_dp     <= shadow_dp_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.anode_n      <= OFF;
            bus.dp_n         <= 1'b1;
            bus.digit_nibble <= '0;
            bus.digit_idx    <= '0;
            bus.frame_tick   <= 1'b0;
            bus.slot_state   <= SLOT_IDLE;
        end else begin
            bus.digit_idx  <= idx_nxt;
            bus.frame_tick <= slot_first && (idx_nxt == '0);
            if (show) begin
                bus.slot_state   <= SLOT_SHOW;
                bus.digit_nibble <= shadow_nxt[4*int'(idx_nxt) +: 4];
                if (suppress[idx_nxt]) begin
                    bus.anode_n <= OFF;
                    bus.dp_n    <= 1'b1;
                end else begin
                    bus.anode_n <= ~(NUM_DIGITS'(1) << idx_nxt);
                    bus.dp_n    <= ~shadow_dp_nxt[idx_nxt];
                end
            end else begin
                bus.slot_state <= SLOT_GUARD;
                bus.anode_n    <= OFF;
                bus.dp_n       <= 1'b1;
            end
        end
    end

endmodule
